// File: rtl/lenet_in_pkg.sv
// Shared constants and types for the LeNet input ping-pong frame buffer.
package lenet_in_pkg;

    localparam int W            = 32;
    localparam int H            = 32;
    localparam int FRAME_PIXELS = W * H;
    localparam int ADDR_W       = 10;
    localparam int DATA_WIDTH   = 8;

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_DROP = 1'b1
    } wr_state_t;

    typedef logic signed [DATA_WIDTH-1:0] q8_t;

    // Saturating 8-bit increment for event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dp_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is not reset so it maps onto block RAM; only the output
// register is cleared.
module dp_ram_1r1w #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk_in_100,
    input  logic          arst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port.
    always_ff @(posedge clk_in_100) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Read port: 1-cycle latency, holds its value while rd_en is low.
    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n)    rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lenet_in_pingpong.sv
// Ping-pong frame buffer between the quantizer stream and the LeNet core.
// Frames are written into one of two banks; a completed bank is presented
// to the CNN until it is consumed. Malformed frames are flagged and
// discarded, and whole frames are dropped while both banks are held.
module lenet_in_pingpong
    import lenet_in_pkg::*;
#(
    parameter int W          = lenet_in_pkg::W,
    parameter int H          = lenet_in_pkg::H,
    parameter int DATA_WIDTH = lenet_in_pkg::DATA_WIDTH,
    parameter int ADDR_W     = lenet_in_pkg::ADDR_W
) (
    input  logic                         clk_in_100,
    input  logic                         arst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_pixel,
    input  logic                         in_line_last,
    input  logic                         in_frame_last,
    input  logic                         rd_en,
    input  logic        [ADDR_W-1:0]     rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         frame_ready,
    output logic                         frame_bank,
    input  logic                         frame_consume,
    output logic                         frame_err,
    output logic        [7:0]            frames_dropped
);

    localparam int                COL_W    = $clog2(W);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(W * H - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(W - 1);

    wr_state_t         state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [COL_W-1:0]  col;
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;

    logic fill_smp;   // sample arriving while filling
    logic drop_frm;   // first sample of a frame aimed at a held bank
    logic bad_smp;    // framing flags disagree with the write position
    logic err_smp;    // malformed sample, partial frame is abandoned
    logic wr_smp;     // well-formed sample written to the bank
    logic done;       // last sample of a well-formed frame
    logic consume;    // accepted release of the read bank

    // Write FSM: state register.
    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) state <= WR_FILL;
        else         state <= state_nxt;
    end

    // Write FSM: next state. Drops and errors without frame_last need to
    // skip the rest of the frame before the next one can start.
    always_comb begin
        state_nxt = state;
        case (state)
            WR_FILL: if ((drop_frm || err_smp) && !in_frame_last) state_nxt = WR_DROP;
            WR_DROP: if (in_valid && in_frame_last)               state_nxt = WR_FILL;
            default: state_nxt = WR_FILL;
        endcase
    end

    // Write FSM: per-sample decode. A held bank at frame start wins over the
    // framing checks, so a dropped frame never raises frame_err.
    always_comb begin
        fill_smp = in_valid && (state == WR_FILL);
        drop_frm = fill_smp && (wr_ptr == '0) && full[wr_bank];
        bad_smp  = (in_frame_last != (wr_ptr == LAST_PTR)) ||
                   (in_line_last  != (col == LAST_COL));
        err_smp  = fill_smp && !drop_frm && bad_smp;
        wr_smp   = fill_smp && !drop_frm && !bad_smp;
        done     = wr_smp && (wr_ptr == LAST_PTR);
        consume  = frame_consume && full[rd_bank];
    end

    // Write position; restarts at 0 after a completed or abandoned frame.
    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            col    <= '0;
        end else if (err_smp || done) begin
            wr_ptr <= '0;
            col    <= '0;
        end else if (wr_smp) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            col    <= col + COL_W'(1);
        end
    end

    // Bank ownership. Completion and consume always touch different full
    // bits (a bank being filled is never full), so both may fire together.
    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (consume) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Error pulse and saturating drop counter.
    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) begin
            frame_err      <= 1'b0;
            frames_dropped <= 8'd0;
        end else begin
            frame_err <= err_smp;
            if (drop_frm) frames_dropped <= sat_inc8(frames_dropped);
        end
    end

    assign frame_ready = full[rd_bank];
    assign frame_bank  = rd_bank;

    dp_ram_1r1w #(
        .AW (ADDR_W + 1),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk_in_100 (clk_in_100),
        .arst_n     (arst_n),
        .we         (wr_smp),
        .wr_addr    ({wr_bank, wr_ptr}),
        .wr_data    (in_pixel),
        .rd_en      (rd_en),
        .rd_addr    ({rd_bank, rd_addr}),
        .rd_data    (rd_data)
    );

endmodule
